// File: rtl/xs3_bcd_seq_ctrl_pkg.sv
// Shared types and constants for the Excess-3 to BCD digit sequencer.
// Optional feature macro used by the top: XS3_EARLY_ABORT_EN.
package xs3_bcd_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_MIN     = 4'h3;
  localparam logic [3:0] XS3_MAX     = 4'hC;
  localparam logic [3:0] BCD_ILLEGAL = 4'hF;

endpackage

// File: rtl/xs3_bcd_seq_ctrl_digit_conv.sv
// Combinational single-digit Excess-3 to BCD converter with illegal-code flag.
// Codes outside 3..12 map to BCD_ILLEGAL.
module xs3_digit_conv
  import xs3_bcd_seq_ctrl_pkg::*;
(
  input  logic [3:0] xs3_i,
  output logic [3:0] bcd_o,
  output logic       illegal_o
);

  assign illegal_o = (xs3_i < XS3_MIN) || (xs3_i > XS3_MAX);
  assign bcd_o     = illegal_o ? BCD_ILLEGAL : (xs3_i - XS3_OFFSET);

endmodule

// File: rtl/xs3_bcd_seq_ctrl.sv
// Multi-digit Excess-3 to BCD sequencer: one shared digit converter, LSB-first, one digit per clock.
// Define XS3_EARLY_ABORT_EN to finish the word at the first illegal digit.
module xs3_bcd_seq_ctrl
  import xs3_bcd_seq_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       hold_q, hold_d;
  logic [W-1:0]       data_q, data_d;
  logic [DIGITS-1:0]  mask_q, mask_d;

  logic [3:0]         cur_xs3;
  logic [3:0]         cur_bcd;
  logic               cur_ill;
  logic               last_digit;
  logic               stop;

  assign cur_xs3    = hold_q[{idx_q, 2'b00} +: 4];
  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

  xs3_digit_conv u_conv (
    .xs3_i     (cur_xs3),
    .bcd_o     (cur_bcd),
    .illegal_o (cur_ill)
  );

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    data_d  = data_q;
    mask_d  = mask_q;
    stop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          data_d  = '0;
          mask_d  = '0;
          idx_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        data_d[{idx_q, 2'b00} +: 4] = cur_bcd;
        mask_d[idx_q]               = cur_ill;
`ifdef XS3_EARLY_ABORT_EN
        stop = last_digit || cur_ill;
`else
        stop = last_digit;
`endif
        // idx only advances when another digit remains, so it never wraps.
        if (stop) state_d = ST_DONE;
        else      idx_d   = idx_q + 1'b1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign out_data     = data_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

endmodule

// File: tb/tb_xs3_bcd_seq_ctrl.sv
// Scoreboard bench for xs3_bcd_seq_ctrl (DIGITS=4); expectations adapt to XS3_EARLY_ABORT_EN.
module tb_xs3_bcd_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0]      data;
    logic [DIGITS-1:0] mask;
    int                lat;
    int                t_acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_err;
  logic [DIGITS-1:0] out_err_mask;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  bit   seen     = 1'b0;
  exp_t sb_q[$];

  xs3_bcd_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_err_mask (out_err_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference conversion of a whole word, independent of the sequencer structure.
  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    bit   aborted = 1'b0;
    logic [3:0] c;
    e.data = '0;
    e.mask = '0;
    e.lat  = DIGITS + 1;
    e.t_acc = 0;
    for (int k = 0; k < DIGITS; k++) begin
      c = w[4*k +: 4];
      if (!aborted) begin
        if (c >= 4'd3 && c <= 4'd12) begin
          e.data[4*k +: 4] = c - 4'd3;
        end else begin
          e.data[4*k +: 4] = 4'hF;
          e.mask[k] = 1'b1;
`ifdef XS3_EARLY_ABORT_EN
          aborted = 1'b1;
          e.lat   = k + 2;
`endif
        end
      end
    end
    return e;
  endfunction

  // Drives one word; returns once the accepting edge has passed.
  task automatic send(input logic [W-1:0] w, input bit expect_result);
    exp_t e;
    bit   ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e = model(w);
      e.t_acc = cyc;
      if (expect_result) sb_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    #1;
  endtask

  // Output monitor: compares every DONE cycle against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc - sb_q[0].t_acc), 32'(sb_q[0].lat));
          seen = 1'b1;
        end
        check("out_data", 32'(out_data), 32'(sb_q[0].data));
        check("out_err_mask", 32'(out_err_mask), 32'(sb_q[0].mask));
        check("out_err", 32'(out_err), 32'(|sb_q[0].mask));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_mask", 32'(out_err_mask), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);

    // Directed words: legal, illegal, all-illegal, range edges.
    send(16'h3C84, 1'b1); drain();
    send(16'h5D34, 1'b1); drain();
    send(16'hF210, 1'b1); drain();
    send(16'h3CC3, 1'b1); drain();
    send(16'hD3C2, 1'b1); drain();

    // Back-pressure: consumer stalls for 10 cycles in DONE.
    out_ready = 1'b0;
    send(16'h4567, 1'b1);
    for (int i = 0; i < 50 && !out_valid; i++) @(posedge clk);
    check("bp_reached_done", 32'(out_valid), 32'd1);
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Input activity during CONV must be ignored.
    send(16'h7A93, 1'b1);
    @(posedge clk);
    #1 begin in_valid = 1'b1; in_data = 16'hCCCC; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1 check("no_extra_word", 32'(out_valid), 32'd0);

    // Reset during the second CONV cycle discards the word.
    send(16'h9876, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_mask", 32'(out_err_mask), 32'd0);
    repeat (8) @(posedge clk);
    #1 check("midrst_no_result", 32'(out_valid), 32'd0);

    // Random words with a mix of legal and illegal digits.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < DIGITS; k++) w[4*k +: 4] = 4'($urandom_range(0, 15));
      send(w, 1'b1);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
